cnn_layer_accel_weight_seq_ctrl: RTL and testbench
==================================================

CNN_LAYER_ACCEL_WEIGHT_SEQ_CTRL -- requirements
Module: cnn_layer_accel_weight_seq_ctrl

Interface
REQ-001 Parameter NUM_SEQ_VALUES, default `NUM_WHT_SEQ_VALUES` (5): number of entries per pass of the weight sequence table.
REQ-002 Parameter C_RDADDR_WIDTH, default clog2(NUM_SEQ_VALUES) (3): table read-address width.
REQ-003 Parameter C_REPEAT_WIDTH, default 16: width of the pass-count input.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to begin a sequence run; sampled only in IDLE.
REQ-007 num_repeat  input  C_REPEAT_WIDTH  number of full table passes; latched when start is accepted.
REQ-008 stall  input  1  downstream back-pressure; while high, no read is issued.
REQ-009 rdAddr  output  C_RDADDR_WIDTH  weight sequence table read address.
REQ-010 rden  output  1  read strobe; a read is issued in every cycle that rden is high.
REQ-011 seq_valid  output  1  table output (seq_dout0/seq_dout1) is valid this cycle.
REQ-012 seq_last  output  1  qualifies seq_valid; marks the final entry of the final pass.
REQ-013 busy  output  1  high in RUN and DRAIN.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-016 In IDLE, start=1 with num_repeat>0 SHALL latch num_repeat, clear the address and pass counters, and enter RUN on the next edge.
REQ-017 In IDLE, start=1 with num_repeat=0 SHALL issue no reads, stay in IDLE, and pulse done in the following cycle.
REQ-018 start SHALL be ignored in RUN and DRAIN, and num_repeat changes after latching SHALL have no effect.
REQ-019 rden SHALL equal (state==RUN) AND NOT stall, combinationally.
REQ-020 rdAddr SHALL be driven from a register. It advances by 1 after each issued read, wraps from NUM_SEQ_VALUES-1 to 0, and holds while stalled.
REQ-021 The pass counter SHALL increment on each wrap.
REQ-022 The read issued at address NUM_SEQ_VALUES-1 during pass num_repeat-1 is the final read; RUN SHALL go to DRAIN on the edge that ends that read.
REQ-023 seq_valid SHALL be rden registered by one cycle, matching the table's one-cycle read latency.
REQ-024 seq_last SHALL be high only together with the seq_valid of the final read.
REQ-025 In DRAIN, done SHALL pulse for exactly one cycle in the cycle after the final seq_valid, and the FSM SHALL return to IDLE.
REQ-026 busy SHALL be registered, high in RUN and DRAIN, and low in the done cycle.
REQ-027 A start in the done cycle SHALL be accepted, because the FSM is already in IDLE.
REQ-028 stall has no effect in IDLE or DRAIN, and the final seq_valid is never withheld.
REQ-029 The total number of reads per run SHALL be exactly num_repeat × NUM_SEQ_VALUES, in address order 0..NUM_SEQ_VALUES-1 repeated.
REQ-030 The pass and address counters SHALL not overflow for num_repeat up to 2^C_REPEAT_WIDTH-1.

Reset
REQ-031 rst low SHALL asynchronously force: state IDLE; rdAddr, rden, seq_valid, seq_last, busy and done to 0; and all counters to 0.
REQ-032 Reset asserted mid-run SHALL abort the run, with no done pulse and no seq_valid for a read that was in flight.
REQ-033 After rst deasserts, the block SHALL require a new start before issuing any read.

Verification
REQ-034 Basic run: start at cycle 0 with num_repeat=2 and stall=0 -> rden high in cycles 1..10 with rdAddr 0,1,2,3,4,0,1,2,3,4; seq_valid in cycles 2..11; seq_last in cycle 11 only; done in cycle 12 only; busy in cycles 1..11.
REQ-035 Stall: num_repeat=1, stall high in cycles 3-4 -> rden low and rdAddr holding at 2 in cycles 3-4, reads resume at address 2 in cycle 5, 5 reads total, done in cycle 9.
REQ-036 Zero passes: start with num_repeat=0 -> rden never asserted, busy stays 0, done pulses in cycle 1.
REQ-037 Ignored start and back-to-back runs: start pulsed in cycle 4 of a run -> no effect. Start in the done cycle -> a second run begins with rdAddr=0 on the next cycle.
REQ-038 Reset mid-run: rst low during cycle 6 of a num_repeat=3 run -> all outputs read 0 within that cycle (asynchronous), no done pulse, no seq_valid afterwards until the next start.

Source files
------------

// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
// Weight sequence table read controller: walks the table num_repeat times in address order,
// tracks the one-cycle read latency, and flags the last entry and run completion.
module cnn_layer_accel_weight_seq_ctrl #(
  parameter int unsigned NUM_SEQ_VALUES = 5,
  parameter int unsigned C_RDADDR_WIDTH = (NUM_SEQ_VALUES > 1) ? $clog2(NUM_SEQ_VALUES) : 1,
  parameter int unsigned C_REPEAT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [C_REPEAT_WIDTH-1:0] num_repeat,
  input  logic                      stall,
  output logic [C_RDADDR_WIDTH-1:0] rdAddr,
  output logic                      rden,
  output logic                      seq_valid,
  output logic                      seq_last,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  localparam logic [C_RDADDR_WIDTH-1:0] LastAddr = C_RDADDR_WIDTH'(NUM_SEQ_VALUES - 1);

  state_e                    state_q, state_d;
  logic [C_RDADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_REPEAT_WIDTH-1:0] pass_q, pass_d;
  logic [C_REPEAT_WIDTH-1:0] repeat_q, repeat_d;
  logic                      seq_valid_q, seq_valid_d;
  logic                      seq_last_q, seq_last_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic last_addr;
  logic last_pass;
  logic final_rd;

  always_comb begin
    rden      = (state_q == StRun) && !stall;
    last_addr = (addr_q == LastAddr);
    // repeat_q is never zero while in StRun, so the subtraction cannot wrap there.
    last_pass = (pass_q == (repeat_q - C_REPEAT_WIDTH'(1)));
    final_rd  = rden && last_addr && last_pass;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pass_d   = pass_q;
    repeat_d = repeat_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_repeat != '0) begin
            repeat_d = num_repeat;
            addr_d   = '0;
            pass_d   = '0;
            state_d  = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (rden) begin
          if (last_addr) begin
            addr_d = '0;
            if (last_pass) begin
              state_d = StDrain;
            end else begin
              pass_d = pass_q + C_REPEAT_WIDTH'(1);
            end
          end else begin
            addr_d = addr_q + C_RDADDR_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        // The final seq_valid is showing this cycle; completion follows on the next one.
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    seq_valid_d = rden;
    seq_last_d  = final_rd;
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      pass_q      <= '0;
      repeat_q    <= '0;
      seq_valid_q <= 1'b0;
      seq_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      repeat_q    <= repeat_d;
      seq_valid_q <= seq_valid_d;
      seq_last_q  <= seq_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rdAddr    = addr_q;
  assign seq_valid = seq_valid_q;
  assign seq_last  = seq_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_ctrl.sv
// Bench for the weight sequence controller: a read-count model checked every cycle, plus
// per-cycle traces pinned against hand-computed timelines.
module tb_cnn_layer_accel_weight_seq_ctrl;

  localparam int N  = 5;
  localparam int AW = 3;
  localparam int RW = 16;
  localparam int TL = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] num_repeat = '0;
  logic          stall = 1'b0;
  logic [AW-1:0] rdAddr;
  logic          rden, seq_valid, seq_last, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  cnn_layer_accel_weight_seq_ctrl #(
    .NUM_SEQ_VALUES(N),
    .C_RDADDR_WIDTH(AW),
    .C_REPEAT_WIDTH(RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_repeat(num_repeat),
    .stall     (stall),
    .rdAddr    (rdAddr),
    .rden      (rden),
    .seq_valid (seq_valid),
    .seq_last  (seq_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: a run is just "total reads owed" and "reads issued so far".
  bit m_run, m_drain, m_done, m_vld, m_lst;
  int m_issued, m_total;

  logic e_rden, e_busy, m_idle, m_final;
  int   e_addr;
  always_comb begin
    e_rden  = m_run && !stall;
    e_addr  = m_issued % N;
    e_busy  = m_run || m_drain;
    m_idle  = !m_run && !m_drain;
    m_final = e_rden && (m_issued == m_total - 1);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run <= 0; m_drain <= 0; m_done <= 0; m_vld <= 0; m_lst <= 0;
      m_issued <= 0; m_total <= 0;
    end else begin
      m_vld   <= e_rden;
      m_lst   <= m_final;
      m_done  <= m_drain || (m_idle && start && num_repeat == 0);
      m_drain <= m_final;
      if (m_run) begin
        if (e_rden) m_issued <= m_issued + 1;
        if (m_final) m_run <= 0;
      end else if (m_idle && start && num_repeat != 0) begin
        m_run    <= 1;
        m_issued <= 0;
        m_total  <= int'(num_repeat) * N;
      end
    end
  end

  // Per-cycle traces of the DUT, indexed by the test-relative cycle number.
  bit rden_tr[TL], valid_tr[TL], last_tr[TL], done_tr[TL], busy_tr[TL];
  int addr_tr[TL];

  always @(negedge clk) begin
    check("rden", int'(rden), int'(e_rden));
    check("rdAddr", int'(rdAddr), e_addr);
    check("seq_valid", int'(seq_valid), int'(m_vld));
    check("seq_last", int'(seq_last), int'(m_lst));
    check("busy", int'(busy), int'(e_busy));
    check("done", int'(done), int'(m_done));
    if (cyc < TL) begin
      rden_tr[cyc]  = rden;
      addr_tr[cyc]  = int'(rdAddr);
      valid_tr[cyc] = seq_valid;
      last_tr[cyc]  = seq_last;
      done_tr[cyc]  = done;
      busy_tr[cyc]  = busy;
    end
  end

  task automatic begin_test();
    for (int i = 0; i < TL; i++) begin
      rden_tr[i] = 0; valid_tr[i] = 0; last_tr[i] = 0;
      done_tr[i] = 0; busy_tr[i] = 0; addr_tr[i] = 0;
    end
    cyc = 0;
  endtask

  task automatic step(input bit s, input int nr, input bit st);
    start      = s;
    num_repeat = RW'(nr);
    stall      = st;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rden"}, int'(rden), 0);
    check({tag, "_rdAddr"}, int'(rdAddr), 0);
    check({tag, "_valid"}, int'(seq_valid), 0);
    check({tag, "_last"}, int'(seq_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int cnt;
    #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) step(0, 0, 0);

    // Basic run, two passes.
    begin_test();
    step(1, 2, 0);
    repeat (15) step(0, 0, 0);
    for (int c = 0; c < 16; c++) begin
      check($sformatf("basic_rden_c%0d", c), int'(rden_tr[c]), (c >= 1 && c <= 10) ? 1 : 0);
      if (c >= 1 && c <= 10) check($sformatf("basic_addr_c%0d", c), addr_tr[c], (c - 1) % 5);
      check($sformatf("basic_valid_c%0d", c), int'(valid_tr[c]), (c >= 2 && c <= 11) ? 1 : 0);
      check($sformatf("basic_last_c%0d", c), int'(last_tr[c]), (c == 11) ? 1 : 0);
      check($sformatf("basic_done_c%0d", c), int'(done_tr[c]), (c == 12) ? 1 : 0);
      check($sformatf("basic_busy_c%0d", c), int'(busy_tr[c]), (c >= 1 && c <= 11) ? 1 : 0);
    end

    // Stall mid-pass, plus stall during the drain cycle.
    begin_test();
    step(1, 1, 0);
    repeat (2) step(0, 0, 0);
    repeat (2) step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    step(0, 0, 1);
    repeat (4) step(0, 0, 0);
    check("stall_rden_c3", int'(rden_tr[3]), 0);
    check("stall_rden_c4", int'(rden_tr[4]), 0);
    check("stall_addr_c3", addr_tr[3], 2);
    check("stall_addr_c4", addr_tr[4], 2);
    check("stall_resume_rden_c5", int'(rden_tr[5]), 1);
    check("stall_resume_addr_c5", addr_tr[5], 2);
    cnt = 0;
    for (int c = 0; c < 13; c++) cnt += int'(rden_tr[c]);
    check("stall_read_count", cnt, 5);
    check("stall_done_c9", int'(done_tr[9]), 1);
    check("stall_done_c8", int'(done_tr[8]), 0);

    // Zero passes.
    begin_test();
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    check("zero_done_c1", int'(done_tr[1]), 1);
    cnt = 0;
    for (int c = 0; c < 5; c++) cnt += int'(rden_tr[c]) + int'(busy_tr[c]);
    check("zero_rden_busy", cnt, 0);

    // Ignored start, changed num_repeat after latching, back-to-back run from the done cycle.
    begin_test();
    step(1, 2, 0);
    repeat (3) step(0, 2, 0);
    step(1, 0, 0);
    step(0, 7, 0);
    repeat (6) step(0, 0, 0);
    step(1, 1, 0);
    repeat (9) step(0, 0, 0);
    check("b2b_done_c12", int'(done_tr[12]), 1);
    cnt = 0;
    for (int c = 0; c < 13; c++) cnt += int'(rden_tr[c]);
    check("b2b_first_reads", cnt, 10);
    check("b2b_rden_c13", int'(rden_tr[13]), 1);
    check("b2b_addr_c13", addr_tr[13], 0);
    check("b2b_done_c19", int'(done_tr[19]), 1);

    // Reset asserted inside cycle 6 of a three-pass run.
    begin_test();
    step(1, 3, 0);
    repeat (5) step(0, 0, 0);
    #2 rst = 1'b0;
    #1 check_outputs_zero("midrst");
    repeat (2) step(0, 0, 0);
    rst = 1'b1;
    repeat (8) step(0, 0, 0);
    cnt = 0;
    for (int c = 6; c < 17; c++) cnt += int'(valid_tr[c]) + int'(done_tr[c]) + int'(rden_tr[c]);
    check("midrst_quiet_after", cnt, 0);
    check("midrst_valid_c5", int'(valid_tr[5]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
